// File: rtl/conv_layer_pkg.sv
// Shared constants, serializer state type and lane helper for the conv layer output stage.
package conv_layer_pkg;

  localparam int WIDTH      = 32;
  localparam int ARRAY_SIZE = 6;

  localparam logic [WIDTH-1:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [0:0] {OUT_IDLE, OUT_SHIFT} out_state_t;

  // Lane 0 sits in the most significant word of the row bus.
  function automatic logic [WIDTH-1:0] get_lane(input logic [ARRAY_SIZE*WIDTH-1:0] bus,
                                                input int idx);
    return bus[(ARRAY_SIZE-1-idx)*WIDTH +: WIDTH];
  endfunction

endpackage

// File: rtl/conv_row_fifo.sv
// Synchronous row FIFO (power-of-two depth) with full/empty flags and occupancy count.
module conv_row_fifo #(
  parameter int DATA_W = 192,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [DATA_W-1:0]            i_data,
  input  logic                         i_pop,
  output logic [DATA_W-1:0]            o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = i_push && !o_full;
    pop_ok   = i_pop && !o_empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) mem_d[wr_ptr_q] = i_data;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/conv_layer_output_interface.sv
// Buffers 6-lane result rows and serializes them into a 32-bit valid/ready pixel stream.
// Optional ReLU on lane load: define CONV_OUT_RELU_EN.
module conv_layer_output_interface #(
  parameter int WIDTH      = 32,
  parameter int ARRAY_SIZE = 6,
  parameter int OUT_ROWS   = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ARRAY_SIZE*WIDTH-1:0] i_feature_bus,
  input  logic                        i_feature_valid,
  output logic                        o_feature_ready,
  output logic [WIDTH-1:0]            o_pixel,
  output logic                        o_pixel_valid,
  input  logic                        i_pixel_ready,
  output logic [2:0]                  o_row_idx,
  output logic [2:0]                  o_col_idx,
  output logic                        o_frame_done,
  output logic                        o_overflow
);

  import conv_layer_pkg::*;

  localparam int CW    = $clog2(FIFO_DEPTH+1);
  localparam int BUS_W = ARRAY_SIZE*WIDTH;

  logic [BUS_W-1:0] fifo_data;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count, count_next;
  logic             push, pop, handshake, last_lane;

  out_state_t       state_q, state_d;
  logic [WIDTH-1:0] lane_q [ARRAY_SIZE];
  logic [WIDTH-1:0] lane_d [ARRAY_SIZE];
  logic [2:0]       col_q, col_d, row_q, row_d;
  logic             ready_q, ready_d;
  logic             overflow_q, overflow_d;
  logic             row_avail_q, row_avail_d;

  function automatic logic [WIDTH-1:0] relu(input logic [WIDTH-1:0] v);
`ifdef CONV_OUT_RELU_EN
    return v[WIDTH-1] ? FP32_ZERO : v;
`else
    return v;
`endif
  endfunction

  conv_row_fifo #(.DATA_W(BUS_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .i_rst   (rst_n),
    .i_push  (push),
    .i_data  (i_feature_bus),
    .i_pop   (pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign o_feature_ready = ready_q;
  assign o_pixel         = lane_q[0];
  assign o_pixel_valid   = (state_q == OUT_SHIFT);
  assign o_row_idx       = row_q;
  assign o_col_idx       = col_q;
  assign o_overflow      = overflow_q;
  assign o_frame_done    = handshake && last_lane && (row_q == 3'(OUT_ROWS-1));

  always_comb begin
    handshake = (state_q == OUT_SHIFT) && i_pixel_ready;
    last_lane = (col_q == 3'(ARRAY_SIZE-1));
    push      = i_feature_valid && ready_q && !fifo_full;
    pop       = 1'b0;
    state_d   = state_q;
    lane_d    = lane_q;
    col_d     = col_q;
    row_d     = row_q;

    case (state_q)
      OUT_IDLE: begin
        // row_avail_q is the occupancy seen one edge earlier, so a fresh row waits a cycle.
        if (row_avail_q && !fifo_empty) begin
          pop     = 1'b1;
          state_d = OUT_SHIFT;
        end
      end
      OUT_SHIFT: begin
        if (i_pixel_ready) begin
          for (int i = 0; i < ARRAY_SIZE-1; i++) lane_d[i] = lane_q[i+1];
          if (last_lane) begin
            col_d = 3'd0;
            row_d = (row_q == 3'(OUT_ROWS-1)) ? 3'd0 : row_q + 3'd1;
            if (!fifo_empty) pop = 1'b1;
            else             state_d = OUT_IDLE;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      default: state_d = OUT_IDLE;
    endcase

    if (pop) begin
      for (int i = 0; i < ARRAY_SIZE; i++) lane_d[i] = relu(get_lane(fifo_data, i));
    end

    // No pop credit: readiness reflects occupancy after this edge only.
    count_next  = fifo_count + CW'(push) - CW'(pop);
    ready_d     = (count_next != CW'(FIFO_DEPTH));
    overflow_d  = overflow_q || (i_feature_valid && !ready_q);
    row_avail_d = !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= OUT_IDLE;
      for (int i = 0; i < ARRAY_SIZE; i++) lane_q[i] <= '0;
      col_q       <= '0;
      row_q       <= '0;
      ready_q     <= 1'b1;
      overflow_q  <= 1'b0;
      row_avail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ready_q     <= ready_d;
      overflow_q  <= overflow_d;
      row_avail_q <= row_avail_d;
    end
  end

endmodule

// File: tb/tb_conv_layer_output_interface.sv
// Directed self-checking bench for conv_layer_output_interface (honours CONV_OUT_RELU_EN).
module tb_conv_layer_output_interface;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [191:0] i_feature_bus = '0;
  logic         i_feature_valid = 1'b0;
  logic         o_feature_ready;
  logic [31:0]  o_pixel;
  logic         o_pixel_valid;
  logic         i_pixel_ready = 1'b1;
  logic [2:0]   o_row_idx;
  logic [2:0]   o_col_idx;
  logic         o_frame_done;
  logic         o_overflow;

  int checkCount = 0;
  int errorCount = 0;
  logic [31:0] expQ[$];

  conv_layer_output_interface dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_feature_bus   (i_feature_bus),
    .i_feature_valid (i_feature_valid),
    .o_feature_ready (o_feature_ready),
    .o_pixel         (o_pixel),
    .o_pixel_valid   (o_pixel_valid),
    .i_pixel_ready   (i_pixel_ready),
    .o_row_idx       (o_row_idx),
    .o_col_idx       (o_col_idx),
    .o_frame_done    (o_frame_done),
    .o_overflow      (o_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [191:0] packRow(input logic [31:0] l0, l1, l2, l3, l4, l5);
    return {l0, l1, l2, l3, l4, l5};
  endfunction

  task automatic applyStimulus(input logic [191:0] row);
    i_feature_bus   = row;
    i_feature_valid = 1'b1;
    tick();
    i_feature_valid = 1'b0;
  endtask

  task automatic resetDut();
    rst_n = 1'b1;
    i_feature_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  task automatic drainStream(input string tag, input bit toggle, input int maxCycles);
    int idx = 0;
    int n = expQ.size();
    for (int cyc = 0; cyc < maxCycles && idx < n; cyc++) begin
      i_pixel_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (o_pixel_valid) begin
        checkOutput({tag, " pixel"}, o_pixel, expQ[idx]);
        checkOutput({tag, " col"}, 32'(o_col_idx), 32'(idx % 6));
        if (i_pixel_ready) idx++;
      end
      tick();
    end
    i_pixel_ready = 1'b1;
    checkOutput({tag, " count"}, 32'(idx), 32'(n));
  endtask

  initial begin
    logic [31:0] rowVals [6];
    logic [31:0] v;
    int doneCount;
    int k;

    // Reset values
    rst_n = 1'b1;
    tick();
    checkOutput("rst valid", 32'(o_pixel_valid), 32'd0);
    checkOutput("rst ready", 32'(o_feature_ready), 32'd1);
    checkOutput("rst overflow", 32'(o_overflow), 32'd0);
    checkOutput("rst row", 32'(o_row_idx), 32'd0);
    checkOutput("rst col", 32'(o_col_idx), 32'd0);
    checkOutput("rst pixel", o_pixel, 32'd0);
    checkOutput("rst done", 32'(o_frame_done), 32'd0);
    rst_n = 1'b0;
    tick();

    // Single row: two-cycle latency then six consecutive pixels
    rowVals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    i_pixel_ready = 1'b1;
    applyStimulus(packRow(rowVals[0], rowVals[1], rowVals[2], rowVals[3], rowVals[4], rowVals[5]));
    checkOutput("lat N valid", 32'(o_pixel_valid), 32'd0);
    tick();
    checkOutput("lat N+1 valid", 32'(o_pixel_valid), 32'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      checkOutput("single valid", 32'(o_pixel_valid), 32'd1);
      checkOutput("single pixel", o_pixel, rowVals[i]);
      checkOutput("single col", 32'(o_col_idx), 32'(i));
      checkOutput("single row", 32'(o_row_idx), 32'd0);
      checkOutput("single done", 32'(o_frame_done), 32'd0);
      tick();
    end
    checkOutput("single idle", 32'(o_pixel_valid), 32'd0);

    // Full frame: six rows spaced 6 cycles apart
    resetDut();
    i_pixel_ready = 1'b1;
    doneCount = 0;
    for (int t = 0; t <= 40; t++) begin
      if (t >= 3 && t < 39) begin
        k = t - 3;
        v = 32'h41000000 + 32'((k / 6) * 16 + (k % 6));
        checkOutput("frame valid", 32'(o_pixel_valid), 32'd1);
        checkOutput("frame pixel", o_pixel, v);
        checkOutput("frame col", 32'(o_col_idx), 32'(k % 6));
        checkOutput("frame row", 32'(o_row_idx), 32'(k / 6));
        checkOutput("frame done", 32'(o_frame_done), 32'(k == 35));
      end else if (t > 0) begin
        checkOutput("frame gap valid", 32'(o_pixel_valid), 32'd0);
      end
      if (o_frame_done) doneCount++;
      if (t % 6 == 0 && t < 36) begin
        for (int c = 0; c < 6; c++) rowVals[c] = 32'h41000000 + 32'((t / 6) * 16 + c);
        i_feature_bus   = packRow(rowVals[0], rowVals[1], rowVals[2], rowVals[3], rowVals[4], rowVals[5]);
        i_feature_valid = 1'b1;
      end else begin
        i_feature_valid = 1'b0;
      end
      tick();
    end
    checkOutput("frame pulses", 32'(doneCount), 32'd1);
    checkOutput("frame row wrap", 32'(o_row_idx), 32'd0);
    checkOutput("frame col wrap", 32'(o_col_idx), 32'd0);

    // Backpressure with i_pixel_ready toggling
    resetDut();
    rowVals = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h66666666};
    expQ.delete();
    for (int c = 0; c < 6; c++) expQ.push_back(rowVals[c]);
    applyStimulus(packRow(rowVals[0], rowVals[1], rowVals[2], rowVals[3], rowVals[4], rowVals[5]));
    drainStream("bp", 1'b1, 40);

    // Overflow: one row held in the shifter, then five back-to-back pushes
    resetDut();
    i_pixel_ready = 1'b0;
    expQ.delete();
    for (int c = 0; c < 6; c++) rowVals[c] = 32'h50000000 + 32'(c);
    for (int c = 0; c < 6; c++) expQ.push_back(rowVals[c]);
    applyStimulus(packRow(rowVals[0], rowVals[1], rowVals[2], rowVals[3], rowVals[4], rowVals[5]));
    tick();
    tick();
    checkOutput("ovf held valid", 32'(o_pixel_valid), 32'd1);
    for (int j = 1; j <= 5; j++) begin
      for (int c = 0; c < 6; c++) rowVals[c] = 32'h50000000 + 32'(j * 16 + c);
      if (j < 5) for (int c = 0; c < 6; c++) expQ.push_back(rowVals[c]);
      i_feature_bus   = packRow(rowVals[0], rowVals[1], rowVals[2], rowVals[3], rowVals[4], rowVals[5]);
      i_feature_valid = 1'b1;
      tick();
      checkOutput("ovf ready", 32'(o_feature_ready), 32'(j < 4));
      checkOutput("ovf flag", 32'(o_overflow), 32'(j == 5));
    end
    i_feature_valid = 1'b0;
    tick();
    tick();
    checkOutput("ovf sticky", 32'(o_overflow), 32'd1);
    checkOutput("ovf still full", 32'(o_feature_ready), 32'd0);
    drainStream("ovf drain", 1'b0, 80);
    checkOutput("ovf ready after drain", 32'(o_feature_ready), 32'd1);
    checkOutput("ovf sticky after drain", 32'(o_overflow), 32'd1);

    // Sign-bit lanes: zeroed with ReLU, bit-exact otherwise
    expQ.delete();
`ifdef CONV_OUT_RELU_EN
    expQ = '{32'h00000000, 32'h3F000000, 32'h00000000, 32'h7FC00000, 32'h00000000, 32'h3F800000};
`else
    expQ = '{32'hC0000000, 32'h3F000000, 32'h80000000, 32'h7FC00000, 32'hFFC00000, 32'h3F800000};
`endif
    applyStimulus(packRow(32'hC0000000, 32'h3F000000, 32'h80000000, 32'h7FC00000, 32'hFFC00000, 32'h3F800000));
    drainStream("relu", 1'b0, 30);

    // Reset mid-row with two rows buffered (overflow still set from before)
    i_pixel_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 6; c++) rowVals[c] = 32'h60000000 + 32'(r * 16 + c);
      applyStimulus(packRow(rowVals[0], rowVals[1], rowVals[2], rowVals[3], rowVals[4], rowVals[5]));
    end
    i_pixel_ready = 1'b1;
    tick();
    tick();
    i_pixel_ready = 1'b0;
    checkOutput("midrow col", 32'(o_col_idx), 32'd2);
    checkOutput("midrow pixel", o_pixel, 32'h60000002);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    checkOutput("mrst valid", 32'(o_pixel_valid), 32'd0);
    checkOutput("mrst ready", 32'(o_feature_ready), 32'd1);
    checkOutput("mrst overflow", 32'(o_overflow), 32'd0);
    checkOutput("mrst row", 32'(o_row_idx), 32'd0);
    checkOutput("mrst col", 32'(o_col_idx), 32'd0);
    i_pixel_ready = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("mrst discarded", 32'(o_pixel_valid), 32'd0);
    expQ.delete();
    for (int c = 0; c < 6; c++) rowVals[c] = 32'h70000000 + 32'(c);
    for (int c = 0; c < 6; c++) expQ.push_back(rowVals[c]);
    applyStimulus(packRow(rowVals[0], rowVals[1], rowVals[2], rowVals[3], rowVals[4], rowVals[5]));
    drainStream("fresh", 1'b0, 30);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/conv_layer_output_interface.md
Name: conv_layer_output_interface

Overview:
- Downstream stage of the convolution layer.
- Captures each 6-lane result row (6x32-bit IEEE-754 features) from the kernel array.
- Buffers rows in a small row FIFO.
- Serializes rows into a single 32-bit valid/ready pixel stream for the activation/pooling stage.
- Tracks row/column position inside a 6x6 output feature map and flags frame completion and dropped rows.

Parameters:
- WIDTH, 32: bits per feature (IEEE-754 single).
- ARRAY_SIZE, 6: lanes per input row; also output columns per row.
- OUT_ROWS, 6: rows per output feature map (8x8 image, 3x3 kernel).
- FIFO_DEPTH, 4: row entries buffered; power of two.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-high (asserted = 1 despite the suffix).
- i_feature_bus  in  ARRAY_SIZE*WIDTH  result row; lane 0 = bits [ARRAY_SIZE*WIDTH-1 -: WIDTH], lane 5 = bits [WIDTH-1:0].
- i_feature_valid  in  1  i_feature_bus holds a complete row this cycle.
- o_feature_ready  out  1  FIFO can accept a row.
- o_pixel  out  WIDTH  serialized feature.
- o_pixel_valid  out  1  o_pixel is valid.
- i_pixel_ready  in  1  consumer accepts o_pixel.
- o_row_idx  out  3  row of current o_pixel, 0..OUT_ROWS-1.
- o_col_idx  out  3  column of current o_pixel, 0..ARRAY_SIZE-1.
- o_frame_done  out  1  one-cycle pulse on the handshake of the last pixel of a frame.
- o_overflow  out  1  sticky; a row arrived while not ready.

Behaviour:
- Reset values: all outputs 0 except o_feature_ready = 1.
  - FIFO emptied; state IDLE; counters 0; o_overflow cleared.
  - Reset mid-operation discards buffered and in-flight data at that edge.
- Push: row written when i_feature_valid && o_feature_ready.
  - o_feature_ready = !fifo_full, registered from occupancy. No same-cycle pop credit, so a full FIFO refuses a push even if a pop happens that cycle.
- Drop: i_feature_valid && !o_feature_ready discards the row and sets o_overflow (held until reset). The upstream array has no backpressure.
- Serializer FSM:
  - IDLE: fifo non-empty -> pop the row into a 6-lane shift register, go to SHIFT. Otherwise stay.
  - SHIFT: o_pixel_valid = 1, o_pixel = current lane.
    - On i_pixel_ready, advance one lane.
    - After lane 5 handshakes: if fifo non-empty, pop the next row directly and stay in SHIFT (back-to-back, no bubble); else go to IDLE.
- Stream rules:
  - o_pixel, o_row_idx and o_col_idx stay stable while o_pixel_valid && !i_pixel_ready.
  - o_pixel_valid never drops without a handshake.
- Latency: a row accepted at edge N (empty FIFO, IDLE) gives o_pixel_valid = 1 with lane 0 after edge N+2.
  - Sustained throughput is 1 pixel/cycle, so one row per 6 cycles. Upstream must space rows at least 6 cycles apart to avoid fill-up.
- Counters:
  - o_col_idx increments per pixel handshake and wraps 5->0.
  - o_row_idx increments on the col wrap and wraps OUT_ROWS-1->0.
  - o_frame_done asserts while the pixel at row OUT_ROWS-1, col ARRAY_SIZE-1 is presented with i_pixel_ready = 1.
- Simultaneous push and pop at non-full: both occur, occupancy unchanged.
- Push into an empty FIFO while IDLE: the pop happens on the following cycle (no bypass).

Optional Feature:
- Macro: CONV_OUT_RELU_EN.
- Defined: ReLU is applied as each lane is loaded into the shift register. A lane with bit 31 = 1 is replaced by 32'h0000_0000. This covers negatives, -0.0 and negative-sign NaNs; other values pass unchanged. No added latency.
- Undefined: lanes pass bit-exact.

Decomposition:
- Package conv_layer_pkg holds:
  - WIDTH and ARRAY_SIZE constants.
  - typedef enum logic [0:0] {OUT_IDLE, OUT_SHIFT} out_state_t.
  - FP32_ZERO = 32'h0.
  - Lane-extract function get_lane(bus, idx).
- Sub-module conv_row_fifo holds the synchronous FIFO of ARRAY_SIZE*WIDTH-bit entries, with full, empty and count outputs. The top contains the FSM, counters and the optional ReLU.

Test Plan:
- Single row, lanes {3F800000, 40000000, 40400000, 40800000, 40A00000, 40C00000}, i_pixel_ready = 1:
  - pixels 1.0..6.0 appear in lane order on 6 consecutive cycles, the first 2 cycles after the push;
  - col 0..5, row 0.
- Six rows spaced 6 cycles apart:
  - 36 pixels with no bubbles after the first;
  - o_frame_done is a single pulse on the 36th;
  - row/col return to 0.
- Backpressure: toggle i_pixel_ready 1010... during a row -> each pixel holds stable until accepted; order and values unchanged.
- Overflow: hold i_pixel_ready = 0 and push 5 rows back-to-back -> o_feature_ready falls after 4 pushes; the 5th is dropped; o_overflow = 1 and stays 1.
- Row {C0000000 (-2.0), 3F000000, 80000000, 7FC00000, FFC00000, 3F800000}:
  - with CONV_OUT_RELU_EN: {0, 3F000000, 0, 7FC00000, 0, 3F800000};
  - without: bit-exact.
- Assert rst_n for one cycle mid-row with 2 rows buffered -> next cycle o_pixel_valid = 0, o_feature_ready = 1, o_overflow = 0, indices 0; a fresh push streams from lane 0.
